// File: rtl/jtframe_dma_pkg.sv
// Shared definitions for the jtframe RAM block-copy engine.
// State encoding and source-read pipeline depth.
package jtframe_dma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        COPY   = 2'd2,
        FINISH = 2'd3
    } dma_state_t;

    // Source RAM read latency, in cen cycles, hidden by the PRIME state
    localparam int PIPE_DEPTH = 1;

endpackage

// File: rtl/jtframe_ram_dma.sv
// Block-copy engine between two single-port synchronous RAMs, one word per cen cycle.
// Define JTFRAME_DMA_FILL_EN to add a constant-fill mode (fill, fill_val ports).
module jtframe_ram_dma
    import jtframe_dma_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int LW = 11
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [LW-1:0] len,
`ifdef JTFRAME_DMA_FILL_EN
    input  logic          fill,
    input  logic [DW-1:0] fill_val,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_q,
    output logic [AW-1:0] dst_addr,
    output logic [DW-1:0] dst_data,
    output logic          dst_we
);

    dma_state_t    st, st_nx;
    logic [LW-1:0] cnt, cnt_nx;
    logic [AW-1:0] src_addr_nx, dst_addr_nx;
    logic          dst_we_nx;
    logic          fill_l;
    logic [DW-1:0] fill_val_l;

    // Read-data stage: cen_p1 marks the clock right after a cen edge.
    // When cen runs every clock src_q is used directly; with gapped cen the
    // word is parked in q_hold_p1 before the RAM moves to the next address.
    logic          cen_p1;
    logic [DW-1:0] q_hold_p1;
    logic [DW-1:0] rdata;

    assign rdata = cen_p1 ? src_q : q_hold_p1;

`ifdef JTFRAME_DMA_FILL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_l     <= 1'b0;
            fill_val_l <= '0;
        end else if (st == IDLE && cen && start) begin
            fill_l     <= fill;
            fill_val_l <= fill_val;
        end
    end
`else
    assign fill_l     = 1'b0;
    assign fill_val_l = '0;
`endif

    always_comb begin
        st_nx       = st;
        cnt_nx      = cnt;
        src_addr_nx = src_addr;
        dst_addr_nx = dst_addr;
        dst_we_nx   = dst_we;
        case (st)
            IDLE: begin
                if (cen && start) begin
                    cnt_nx      = len;
                    src_addr_nx = src_base;
                    dst_addr_nx = dst_base;
                    if (len == '0) begin
                        st_nx = FINISH;
`ifdef JTFRAME_DMA_FILL_EN
                    end else if (fill) begin
                        st_nx     = COPY;
                        dst_we_nx = 1'b1;
`endif
                    end else begin
                        st_nx = PRIME;
                    end
                end
            end
            PRIME: begin
                if (cen) begin
                    src_addr_nx = src_addr + AW'(PIPE_DEPTH);
                    dst_we_nx   = 1'b1;
                    st_nx       = COPY;
                end
            end
            COPY: begin
                if (cen) begin
                    cnt_nx = cnt - LW'(1);
                    if (!fill_l)
                        src_addr_nx = src_addr + AW'(PIPE_DEPTH);
                    if (cnt == LW'(1)) begin
                        dst_we_nx = 1'b0;
                        st_nx     = FINISH;
                    end else begin
                        dst_addr_nx = dst_addr + AW'(1);
                    end
                end
            end
            FINISH: begin
                st_nx = IDLE;
            end
            default: begin
                st_nx     = IDLE;
                dst_we_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= '0;
            src_addr  <= '0;
            dst_addr  <= '0;
            dst_we    <= 1'b0;
            cen_p1    <= 1'b0;
            q_hold_p1 <= '0;
        end else begin
            st        <= st_nx;
            cnt       <= cnt_nx;
            src_addr  <= src_addr_nx;
            dst_addr  <= dst_addr_nx;
            dst_we    <= dst_we_nx;
            cen_p1    <= cen;
            if (cen_p1)
                q_hold_p1 <= src_q;
        end
    end

    assign busy = (st == PRIME) || (st == COPY);
    assign done = (st == FINISH);

    always_comb begin
        dst_data = '0;
        if (dst_we)
            dst_data = fill_l ? fill_val_l : rdata;
    end

endmodule

// File: doc/jtframe_ram_dma.md
Name: jtframe_ram_dma

Overview:
- Block-copy engine that drives the port side of single-port synchronous RAMs.
- It reads a source RAM (address out, registered data in, 1-clk read latency) and writes a destination RAM (address, data and write-enable out, qualified by the shared cen).
- Typical uses: sprite/object buffer copy at VBLANK and palette shadow copy. It sits between the game RAMs and the CPU bus mux, and owns the RAM ports while busy=1.

Parameters:
- DW, 8: data width of both RAMs.
- AW, 10: address width of both RAMs; addresses wrap modulo 2**AW.
- LW, 11: length counter width; LW must be at least AW+1 so that a full-RAM copy is possible.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cen  in  1  clock enable; the engine advances only on cycles with cen=1
- start  in  1  request; sampled on a cen cycle while idle
- src_base  in  AW  first source address, latched at start
- dst_base  in  AW  first destination address, latched at start
- len  in  LW  number of words, latched at start
- busy  out  1  engine owns the RAM ports
- done  out  1  one-clk pulse at completion
- src_addr  out  AW  source RAM address
- src_q  in  DW  source RAM data, valid 1 clk after src_addr changes
- dst_addr  out  AW  destination RAM address
- dst_data  out  DW  destination RAM write data
- dst_we  out  1  destination write enable; the RAM writes on cen && dst_we

Behaviour:
- Reset (asynchronous):
  - State IDLE; busy=0, done=0, dst_we=0.
  - src_addr=0, dst_addr=0, dst_data=0; internal counters 0.
  - Reset mid-transfer aborts immediately. No further write occurs.
- State IDLE:
  - On a cen cycle with start=1: latch src_base, dst_base and len, and set busy=1.
  - If len!=0, go to PRIME and drive src_addr=src_base.
  - If len==0, go to FINISH with no writes.
  - start=0, or a cycle without cen, leaves the engine in IDLE.
- State PRIME (one cen cycle): src_addr advances to src_base+1. The previous address's data is now valid on src_q. Go to COPY.
- State COPY (pipelined): on each cen cycle k (k=0..len-1):
  - dst_we=1, dst_addr=dst_base+k, dst_data=src_q (the data for src_base+k).
  - src_addr=src_base+k+2.
- Throughput and latency:
  - One word per cen cycle.
  - Total cen cycles from start to done is len+2 (start, PRIME, len writes).
  - On the cen cycle after the last write: dst_we=0, go to FINISH.
- dst_we is registered and asserted only in COPY. It is held stable through non-cen clocks, so the RAM writes exactly once per word.
- State FINISH: done=1 for exactly one clk, busy=0, go to IDLE. start is not accepted in FINISH.
- start while busy: ignored, not queued.
- Address arithmetic is AW bits, wrapping (src_base=2**AW-1 is followed by 0). Overlapping source and destination in the same RAM is not supported.
- Gapped cen: src_q must stay stable while cen=0. The source RAM always reads (no read clock enable), and src_addr only changes on cen, so this holds.

Optional Feature:
- JTFRAME_DMA_FILL_EN:
  - Adds inputs fill (1 bit) and fill_val (DW), both latched at start.
  - When fill=1, dst_data=fill_val, src_addr is held at src_base, and PRIME is skipped. Total is len+1 cen cycles.
- Without the macro: ports absent, copy only, behaviour exactly as above.

Decomposition:
- Package jtframe_dma_pkg holds:
  - the state encoding constants IDLE, PRIME, COPY, FINISH (2 bits);
  - the localparam for the pipeline depth (1).
- No sub-module. The single FSM plus one LW-bit down-counter and two AW-bit address counters stays around 150-200 lines.

Test Plan:
- Basic copy, cen=1 always: src RAM[0x10..0x13]={A1,B2,C3,D4}, start with src_base=0x10, dst_base=0x200, len=4 -> dst RAM[0x200..0x203]=A1,B2,C3,D4; done pulses exactly 6 clks after start; busy high during that window; exactly 4 dst_we cycles.
- Gapped cen, 1-in-3 clocks: same transfer -> identical dst contents; done after 6 cen cycles; no double writes (count cen&&dst_we == 4).
- Wrap: AW=10, src_base=0x3FE, dst_base=0x3FF, len=3 -> reads 0x3FE,0x3FF,0x000; writes 0x3FF,0x000,0x001.
- len=0 and start while busy: len=0 -> done 1 clk later, zero writes; a second start mid-transfer -> ignored, the original transfer completes unchanged.
- Reset mid-transfer: assert rst after the 2nd write of a len=8 copy -> busy, dst_we and done go to 0 asynchronously; dst words 2..7 are untouched; the next start works normally.
- With JTFRAME_DMA_FILL_EN: fill=1, fill_val=0x5A, dst_base=0x40, len=5 -> dst RAM[0x40..0x44]=0x5A; done after 6 cen cycles; src_addr constant.
